// File: rtl/tx_arb_pkg.sv
// Shared definitions for the tx packet arbiters.
//   - arb_state_e : arbiter FSM encodings (IDLE=0, XFER=1)
//   - log2        : ceiling log2 with a minimum of 1, for index widths
//   - TX_ARB_SLICE: slice lane i of a flattened bus of w-bit lanes
`ifndef TX_ARB_PKG_SV
`define TX_ARB_PKG_SV

`define TX_ARB_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package tx_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // A one-queue index still needs a 1-bit field, so never return 0.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`endif

// File: rtl/tx_arb_rr_select.sv
// Rotating-priority encoder: picks the first set bit of eligible, searching
// upward from last_served+1 with wrap-around.
//   eligible    in  NUM_QUEUES  request mask
//   last_served in  QSEL_WIDTH  index granted most recently
//   grant_valid out 1           any request present
//   grant_idx   out QSEL_WIDTH  selected index (0 when none)
module tx_arb_rr_select
  import tx_arb_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int QSEL_WIDTH = log2(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] eligible,
  input  logic [QSEL_WIDTH-1:0] last_served,
  output logic                  grant_valid,
  output logic [QSEL_WIDTH-1:0] grant_idx
);

  int idx;

  // Walk from farthest to nearest so the last hit (nearest to the pointer)
  // wins; offset NUM_QUEUES lands back on last_served itself.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NUM_QUEUES; k >= 1; k--) begin
      idx = (int'(last_served) + k) % NUM_QUEUES;
      if (eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[QSEL_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter draining NUM_QUEUES show-ahead FIFOs
// into one tx_queue write port. A granted packet is forwarded whole; any
// nonzero ctrl marks its last word.
//   clk, reset          core clock, async active-high reset
//   src_data/src_ctrl   flattened FIFO heads, queue i at [i*W +: W]
//   src_empty           per-queue FIFO empty
//   src_rd_en           per-queue pop (combinational, one-hot or zero)
//   queue_en            per-queue enable for new grants
//   out_data/ctrl/wr    registered word to tx_queue
//   out_rdy             tx_queue not almost full
//   active_queue, busy  current grant / transfer in progress
//   pkt_done            per-queue pulse with the EOP write
module tx_pkt_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_QUEUES = 4,
  parameter int QSEL_WIDTH = log2(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] src_ctrl,
  input  logic [NUM_QUEUES-1:0]            src_empty,
  output logic [NUM_QUEUES-1:0]            src_rd_en,
  input  logic [NUM_QUEUES-1:0]            queue_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [QSEL_WIDTH-1:0]            active_queue,
  output logic                             busy,
  output logic [NUM_QUEUES-1:0]            pkt_done
);

  arb_state_e                            state;
  logic [QSEL_WIDTH-1:0]                 last_served;
  logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0] q_data;
  logic [NUM_QUEUES-1:0][CTRL_WIDTH-1:0] q_ctrl;
  logic [NUM_QUEUES-1:0]                 eligible;
  logic                                  grant_valid;
  logic [QSEL_WIDTH-1:0]                 grant_idx;
  logic                                  pop;
  logic                                  eop;

  // Packed 2-D view of the flattened heads; lane order matches the bus slicing.
  assign q_data   = src_data;
  assign q_ctrl   = src_ctrl;
  assign eligible = ~src_empty & queue_en;

  tx_arb_rr_select #(
    .NUM_QUEUES (NUM_QUEUES),
    .QSEL_WIDTH (QSEL_WIDTH)
  ) u_rr_select (
    .eligible    (eligible),
    .last_served (last_served),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Pop is gated by out_rdy directly, so only one word can be in flight
  // after tx_queue signals almost-full.
  always_comb begin
    src_rd_en = '0;
    if (state == XFER)
      src_rd_en[active_queue] = ~src_empty[active_queue] & out_rdy;
  end

  assign pop = |src_rd_en;
  assign eop = pop & (|q_ctrl[active_queue]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_served  <= QSEL_WIDTH'(NUM_QUEUES - 1);
      active_queue <= '0;
      busy         <= 1'b0;
      out_wr       <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= '0;
      pkt_done     <= '0;
    end else begin
      out_wr   <= 1'b0;
      pkt_done <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            active_queue <= grant_idx;
            busy         <= 1'b1;
            state        <= XFER;
          end
        end
        XFER: begin
          // queue_en and underruns are ignored here: only EOP ends the grant.
          if (pop) begin
            out_data <= q_data[active_queue];
            out_ctrl <= q_ctrl[active_queue];
            out_wr   <= 1'b1;
            if (eop) begin
              pkt_done[active_queue] <= 1'b1;
              last_served            <= active_queue;
              busy                   <= 1'b0;
              state                  <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
module tb_tx_pkt_arbiter;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NQ = 4;
  localparam int QW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NQ*DW-1:0] src_data;
  logic [NQ*CW-1:0] src_ctrl;
  logic [NQ-1:0]  src_empty;
  logic [NQ-1:0]  src_rd_en;
  logic [NQ-1:0]  queue_en;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_ctrl;
  logic           out_wr;
  logic           out_rdy;
  logic [QW-1:0]  active_queue;
  logic           busy;
  logic [NQ-1:0]  pkt_done;

  tx_pkt_arbiter #(
    .DATA_WIDTH (DW), .CTRL_WIDTH (CW), .NUM_QUEUES (NQ), .QSEL_WIDTH (QW)
  ) dut (
    .clk (clk), .reset (reset),
    .src_data (src_data), .src_ctrl (src_ctrl), .src_empty (src_empty),
    .src_rd_en (src_rd_en), .queue_en (queue_en),
    .out_data (out_data), .out_ctrl (out_ctrl), .out_wr (out_wr),
    .out_rdy (out_rdy), .active_queue (active_queue), .busy (busy),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Show-ahead FIFO model feeding the DUT
  logic [DW-1:0] fd [NQ][16];
  logic [CW-1:0] fc [NQ][16];
  int wp [NQ];
  int rp [NQ];

  logic [NQ-1:0] rd_snap;
  int   multihot;
  int   ord [16];
  int   n_ord;
  logic [DW-1:0] wlog [32];
  int   n_w;
  logic saw_q1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wd(input int q, input int w);
    return 64'hA5A5_0000_0000_0000 | (64'(q) << 8) | 64'(w);
  endfunction

  task automatic drive();
    for (int i = 0; i < NQ; i++) begin
      src_empty[i]          = (wp[i] == rp[i]);
      src_data[i*DW +: DW]  = fd[i][rp[i] % 16];
      src_ctrl[i*CW +: CW]  = fc[i][rp[i] % 16];
    end
  endtask

  task automatic push(input int q, input logic [DW-1:0] d, input logic [CW-1:0] c);
    fd[q][wp[q] % 16] = d;
    fc[q][wp[q] % 16] = c;
    wp[q]++;
    drive();
  endtask

  // Words first..last of an n-word packet; last word carries ctrl 0x80
  task automatic push_words(input int q, input int first, input int last, input int n);
    for (int w = first; w <= last; w++)
      push(q, wd(q, w), (w == n - 1) ? 8'h80 : 8'h00);
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NQ; i++) begin
      wp[i] = 0;
      rp[i] = 0;
      for (int j = 0; j < 16; j++) begin
        fd[i][j] = '0;
        fc[i][j] = '0;
      end
    end
    drive();
  endtask

  // One clock: snapshot pops before the edge, retire them from the model after.
  task automatic step();
    #1;
    rd_snap = src_rd_en;
    if ($countones(rd_snap) > 1) multihot++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++)
      if (rd_snap[i]) rp[i]++;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_fifos();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_pkts(input int npk, input int budget, input logic refill0);
    int   cyc;
    logic refilled;
    cyc = 0;
    refilled = 1'b0;
    n_ord = 0;
    n_w = 0;
    while (n_ord < npk && cyc < budget) begin
      step();
      cyc++;
      if (busy && active_queue == 2'd1) saw_q1 = 1'b1;
      if (out_wr && n_w < 32) begin
        wlog[n_w] = out_data;
        n_w++;
      end
      for (int q = 0; q < NQ; q++)
        if (pkt_done[q] && n_ord < 16) begin
          ord[n_ord] = q;
          n_ord++;
        end
      if (refill0 && pkt_done[0] && !refilled) begin
        push_words(0, 0, 1, 2);
        refilled = 1'b1;
      end
    end
    chk("run_timeout", 64'(cyc < budget), 64'd1);
  endtask

  initial begin
    out_rdy  = 1'b1;
    queue_en = 4'b1111;
    multihot = 0;
    saw_q1   = 1'b0;
    clear_fifos();

    // ---- Test 1: single 3-word packet on queue 0
    push_words(0, 0, 2, 3);
    @(posedge clk);
    #1;
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_active", 64'(active_queue), 64'd0);
    chk("rst_done", 64'(pkt_done), 64'd0);
    chk("rst_data", out_data, 64'd0);
    reset = 1'b0;
    step();
    chk("t1_grant_busy", 64'(busy), 64'd1);
    chk("t1_grant_act", 64'(active_queue), 64'd0);
    chk("t1_grant_wr", 64'(out_wr), 64'd0);
    for (int w = 0; w < 3; w++) begin
      step();
      chk("t1_wr", 64'(out_wr), 64'd1);
      chk("t1_data", out_data, wd(0, w));
      chk("t1_done", 64'(pkt_done), (w == 2) ? 64'h1 : 64'h0);
    end
    chk("t1_ctrl", 64'(out_ctrl), 64'h80);
    chk("t1_busy_end", 64'(busy), 64'd0);
    step();
    chk("t1_wr_after", 64'(out_wr), 64'd0);
    chk("t1_done_after", 64'(pkt_done), 64'd0);

    // ---- Test 2: queues 0,1,3 with 2-word packets, refill 0
    do_reset();
    multihot = 0;
    push_words(0, 0, 1, 2);
    push_words(1, 0, 1, 2);
    push_words(3, 0, 1, 2);
    run_pkts(4, 40, 1'b1);
    chk("t2_npk", 64'(n_ord), 64'd4);
    chk("t2_ord0", 64'(ord[0]), 64'd0);
    chk("t2_ord1", 64'(ord[1]), 64'd1);
    chk("t2_ord2", 64'(ord[2]), 64'd3);
    chk("t2_ord3", 64'(ord[3]), 64'd0);
    chk("t2_nwords", 64'(n_w), 64'd8);
    chk("t2_w2", wlog[2], wd(1, 0));
    chk("t2_w5", wlog[5], wd(3, 1));
    chk("t2_multihot", 64'(multihot), 64'd0);

    // ---- Test 3: queue 1 masked off
    do_reset();
    queue_en = 4'b1101;
    saw_q1 = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      push_words(q, 0, 0, 1);
      push_words(q, 0, 0, 1);
    end
    run_pkts(4, 40, 1'b0);
    chk("t3_ord0", 64'(ord[0]), 64'd0);
    chk("t3_ord1", 64'(ord[1]), 64'd2);
    chk("t3_ord2", 64'(ord[2]), 64'd3);
    chk("t3_ord3", 64'(ord[3]), 64'd0);
    chk("t3_no_q1", 64'(saw_q1), 64'd0);
    queue_en = 4'b1111;

    // ---- Test 4: out_rdy stall after word 2 of 4 on queue 2
    do_reset();
    push_words(2, 0, 3, 4);
    step();
    chk("t4_act", 64'(active_queue), 64'd2);
    step();
    step();
    chk("t4_pre_stall", out_data, wd(2, 1));
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_stall_rd", 64'(rd_snap), 64'd0);
      chk("t4_stall_wr", 64'(out_wr), 64'd0);
      chk("t4_stall_act", 64'(active_queue), 64'd2);
      chk("t4_stall_hold", out_data, wd(2, 1));
    end
    out_rdy = 1'b1;
    step();
    chk("t4_resume_wr", 64'(out_wr), 64'd1);
    chk("t4_resume_data", out_data, wd(2, 2));
    step();
    chk("t4_last", out_data, wd(2, 3));
    chk("t4_done", 64'(pkt_done), 64'h4);

    // ---- Test 5: source underrun on queue 0 with queue 2 waiting
    do_reset();
    push_words(0, 0, 1, 4);
    push_words(2, 0, 0, 1);
    step();
    chk("t5_act", 64'(active_queue), 64'd0);
    step();
    step();
    chk("t5_w1", out_data, wd(0, 1));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_under_wr", 64'(out_wr), 64'd0);
      chk("t5_under_act", 64'(active_queue), 64'd0);
      chk("t5_under_busy", 64'(busy), 64'd1);
    end
    push_words(0, 2, 3, 4);
    step();
    chk("t5_w2", out_data, wd(0, 2));
    step();
    chk("t5_w3", out_data, wd(0, 3));
    chk("t5_done0", 64'(pkt_done), 64'h1);
    step();
    chk("t5_q2_act", 64'(active_queue), 64'd2);
    step();
    chk("t5_q2_data", out_data, wd(2, 0));
    chk("t5_done2", 64'(pkt_done), 64'h4);

    // ---- Test 6: async reset mid-packet on queue 3
    do_reset();
    push_words(3, 0, 3, 4);
    step();
    chk("t6_act", 64'(active_queue), 64'd3);
    step();
    step();
    chk("t6_w1", out_data, wd(3, 1));
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_wr", 64'(out_wr), 64'd0);
    chk("t6_async_busy", 64'(busy), 64'd0);
    chk("t6_async_act", 64'(active_queue), 64'd0);
    chk("t6_async_data", out_data, 64'd0);
    push_words(0, 0, 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("t6_regrant", 64'(active_queue), 64'd0);
    chk("t6_regrant_busy", 64'(busy), 64'd1);
    step();
    chk("t6_q0_data", out_data, wd(0, 0));
    chk("t6_q0_done", 64'(pkt_done), 64'h1);
    step();
    chk("t6_q3_act", 64'(active_queue), 64'd3);
    step();
    chk("t6_q3_data", out_data, wd(3, 2));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
